// File: rtl/ps2_pkg.sv
// Purpose: shared byte constants, FSM state encoding and event layout for the PS/2 front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ps2_pkg;

    // Prefix bytes of set-2 scan sequences
    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;

    // Device status / response bytes that never form part of a key event
    localparam logic [7:0] BYTE_ACK      = 8'hFA;
    localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
    localparam logic [7:0] BYTE_ECHO     = 8'hEE;
    localparam logic [7:0] BYTE_RESEND   = 8'hFE;
    localparam logic [7:0] BYTE_BAT_FAIL = 8'hFC;
    localparam logic [7:0] BYTE_ERR_00   = 8'h00;
    localparam logic [7:0] BYTE_ERR_FF   = 8'hFF;

    // Pause emits as extended 77 once the 7 bytes after E1 have arrived
    localparam logic [7:0] PAUSE_CODE = 8'h77;
    localparam logic [2:0] PAUSE_LAST = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    localparam int EVT_W = 10;

    function automatic logic is_status(input logic [7:0] b);
        return (b == BYTE_ACK)    || (b == BYTE_BAT_OK)   || (b == BYTE_ECHO) ||
               (b == BYTE_RESEND) || (b == BYTE_BAT_FAIL) ||
               (b == BYTE_ERR_00) || (b == BYTE_ERR_FF);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Purpose: show-ahead event FIFO, DEPTH x W, head always visible on dat_o while not empty.
// Latency: a push into an empty FIFO is visible (empty_o=0) the cycle after.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
// Ports: clk_i/reset_i (sync, active-high); push_i/push_dat_i write side;
//        pop_i read side (ignored when empty); dat_o head; full_o/empty_o status.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          pop_ok;
    logic          push_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push_i && (!full_o || pop_ok);
    assign dat_o   = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Purpose: turns PS/2 set-2 scan bytes into make/break key events (E0, F0, E1 pause, status drop).
// Latency: event pushed the cycle after its final byte; evt_valid rises 2 clk after that tick.
// Backpressure: none towards rx; events arriving at a full FIFO are dropped and flagged in overflow.
// Ports: clk, reset (sync, active-high); rx_done_tick/rx_data byte input; rd_en pops head;
//        evt_valid/evt_code/evt_break/evt_ext head event; overflow sticky; err_timeout pulse.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int TIMEOUT_CYC   = 100000,
    parameter int FILTER_REPEAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd_en,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       overflow,
    output logic       err_timeout
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t          state_q, state_d;
    logic [2:0]      pcnt_q, pcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            held_vld_q, held_vld_d;
    logic [8:0]      held_q, held_d;
    logic            push_vld_q;
    evt_t            push_dat_q;
    logic            err_q;
    logic            ovf_q;

    logic            emit;
    evt_t            emit_evt;
    logic            timeout;
    logic            key_match;
    logic            drop;

    logic            fifo_full;
    logic            fifo_empty;
    logic [EVT_W-1:0] fifo_dat;
    evt_t            head;
    logic            pop;

    // Sequence decoder: advances only on byte ticks, except for the idle timeout
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        tcnt_d   = tcnt_q;
        emit     = 1'b0;
        emit_evt = '0;
        timeout  = 1'b0;

        if (rx_done_tick) begin
            tcnt_d        = '0;
            emit_evt.code = rx_data;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == BYTE_E0) begin
                        state_d = ST_EXT;
                    end else if (rx_data == BYTE_F0) begin
                        state_d = ST_BRK;
                    end else if (rx_data == BYTE_E1) begin
                        state_d = ST_PAUSE;
                        pcnt_d  = '0;
                    end else if (!is_status(rx_data)) begin
                        emit = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_data == BYTE_F0) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data == BYTE_E0) begin
                        state_d = ST_EXT;
                    end else if (rx_data == BYTE_E1) begin
                        state_d = ST_PAUSE;
                        pcnt_d  = '0;
                    end else begin
                        emit         = 1'b1;
                        emit_evt.ext = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit         = 1'b1;
                    emit_evt.brk = 1'b1;
                    state_d      = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    emit         = 1'b1;
                    emit_evt.brk = 1'b1;
                    emit_evt.ext = 1'b1;
                    state_d      = ST_IDLE;
                end
                ST_PAUSE: begin
                    // Pause bytes are counted, never inspected
                    if (pcnt_q == PAUSE_LAST) begin
                        emit          = 1'b1;
                        emit_evt.ext  = 1'b1;
                        emit_evt.code = PAUSE_CODE;
                        state_d       = ST_IDLE;
                    end else begin
                        pcnt_d = pcnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                timeout = 1'b1;
                tcnt_d  = '0;
                state_d = ST_IDLE;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // Typematic repeat filter against the single held key; breaks always pass
    always_comb begin
        held_vld_d = held_vld_q;
        held_d     = held_q;
        key_match  = held_vld_q && (held_q == {emit_evt.ext, emit_evt.code});
        drop       = emit && !emit_evt.brk && (FILTER_REPEAT != 0) && key_match;
        if (emit && !drop) begin
            if (!emit_evt.brk) begin
                held_vld_d = 1'b1;
                held_d     = {emit_evt.ext, emit_evt.code};
            end else if (key_match) begin
                held_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            tcnt_q     <= '0;
            held_vld_q <= 1'b0;
            held_q     <= '0;
            push_vld_q <= 1'b0;
            push_dat_q <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            tcnt_q     <= tcnt_d;
            held_vld_q <= held_vld_d;
            held_q     <= held_d;
            push_vld_q <= emit && !drop;
            push_dat_q <= emit_evt;
            err_q      <= timeout;
            if (push_vld_q && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign pop = rd_en && evt_valid;

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .push_i     (push_vld_q),
        .push_dat_i (push_dat_q),
        .pop_i      (pop),
        .dat_o      (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign head        = fifo_dat;
    assign evt_valid   = !fifo_empty;
    // Zero the head fields while empty so stale storage never leaks out
    assign evt_code    = evt_valid ? head.code : 8'h00;
    assign evt_break   = evt_valid && head.brk;
    assign evt_ext     = evt_valid && head.ext;
    assign overflow    = ovf_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
module tb_ps2_scan_sequencer;

    localparam int DEPTH = 4;
    localparam int TCYC  = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       overflow;
    logic       err_timeout;

    int n_chk = 0;
    int n_err = 0;
    bit armed = 1'b0;

    ps2_scan_sequencer #(
        .DEPTH         (DEPTH),
        .TIMEOUT_CYC   (TCYC),
        .FILTER_REPEAT (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd_en        (rd_en),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_break    (evt_break),
        .evt_ext      (evt_ext),
        .overflow     (overflow),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } m_evt_t;

    m_evt_t     exp_q[$];
    logic [7:0] pend[$];
    int         idle_cnt;
    bit         mp_vld;
    m_evt_t     mp_ev;
    bit         hk_vld;
    logic [8:0] hk;
    bit         m_ovf;
    bit         m_err;
    bit         m_pop, m_full, got;
    m_evt_t     ev;
    logic [7:0] b;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete(); pend.delete();
            idle_cnt = 0; mp_vld = 0; hk_vld = 0; hk = '0; m_ovf = 0; m_err = 0;
        end else begin
            m_err  = 0;
            m_full = (exp_q.size() == DEPTH);
            m_pop  = rd_en && (exp_q.size() > 0);
            if (m_pop) void'(exp_q.pop_front());
            if (mp_vld) begin
                if (!m_full || m_pop) exp_q.push_back(mp_ev);
                else m_ovf = 1;
            end
            mp_vld = 0;
            if (rx_done_tick) begin
                idle_cnt = 0;
                b = rx_data;
                got = 0;
                ev = '0;
                pend.push_back(b);
                if (pend[0] == 8'hE1) begin
                    if (pend.size() == 8) begin
                        got = 1; ev.ext = 1; ev.code = 8'h77; pend.delete();
                    end
                end else if (pend.size() == 1) begin
                    if (b == 8'hE0 || b == 8'hF0) begin
                    end else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF}) begin
                        pend.delete();
                    end else begin
                        got = 1; ev.code = b; pend.delete();
                    end
                end else if (pend[0] == 8'hF0) begin
                    got = 1; ev.brk = 1; ev.code = b; pend.delete();
                end else if (pend.size() == 2) begin
                    if (b == 8'hF0) begin
                    end else if (b == 8'hE0 || b == 8'hE1) begin
                        pend.delete(); pend.push_back(b);
                    end else begin
                        got = 1; ev.ext = 1; ev.code = b; pend.delete();
                    end
                end else begin
                    got = 1; ev.ext = 1; ev.brk = 1; ev.code = b; pend.delete();
                end
                if (got) begin
                    if (!ev.brk) begin
                        if (hk_vld && hk == {ev.ext, ev.code}) got = 0;
                        else begin hk_vld = 1; hk = {ev.ext, ev.code}; end
                    end else if (hk_vld && hk == {ev.ext, ev.code}) begin
                        hk_vld = 0;
                    end
                end
                mp_vld = got;
                mp_ev  = ev;
            end else if (pend.size() > 0) begin
                idle_cnt++;
                if (idle_cnt == TCYC) begin
                    pend.delete(); idle_cnt = 0; m_err = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (armed) begin
            chk("cmp_valid", int'(evt_valid), int'(exp_q.size() > 0));
            chk("cmp_code", int'(evt_code), (exp_q.size() > 0) ? int'(exp_q[0].code) : 0);
            chk("cmp_break", int'(evt_break), (exp_q.size() > 0) ? int'(exp_q[0].brk) : 0);
            chk("cmp_ext", int'(evt_ext), (exp_q.size() > 0) ? int'(exp_q[0].ext) : 0);
            chk("cmp_overflow", int'(overflow), int'(m_ovf));
            chk("cmp_err_timeout", int'(err_timeout), int'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [7:0] d);
        @(negedge clk); rx_done_tick = 1'b1; rx_data = d;
        @(negedge clk); rx_done_tick = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic head(input string nm, input int code, input int brk, input int ext);
        chk({nm, "_valid"}, int'(evt_valid), 1);
        chk({nm, "_code"}, int'(evt_code), code);
        chk({nm, "_brk"}, int'(evt_break), brk);
        chk({nm, "_ext"}, int'(evt_ext), ext);
    endtask

    initial begin
        int waited;
        bit seen;
        logic [7:0] seq_pause [8];
        seq_pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; rd_en = 1'b0;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_code", int'(evt_code), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_err", int'(err_timeout), 0);
        reset = 1'b0;

        // single make, latency
        send(8'h1C);
        chk("lat1_valid", int'(evt_valid), 0);
        @(negedge clk);
        head("make1c", 'h1C, 0, 0);
        pop1();
        chk("make1c_popped", int'(evt_valid), 0);

        // break and extended break, in order
        send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h75);
        idle(2);
        head("brk1c", 'h1C, 1, 0);
        pop1();
        head("extbrk75", 'h75, 1, 1);
        pop1();
        chk("brk_empty", int'(evt_valid), 0);

        // typematic repeat filter
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        idle(2);
        head("rep_make", 'h1C, 0, 0);
        pop1();
        head("rep_break", 'h1C, 1, 0);
        pop1();
        head("rep_make2", 'h1C, 0, 0);
        pop1();
        chk("rep_empty", int'(evt_valid), 0);

        // pause sequence, then status bytes alone
        for (int i = 0; i < 8; i++) send(seq_pause[i]);
        send(8'hAA); send(8'hFA);
        idle(2);
        head("pause", 'h77, 0, 1);
        pop1();
        chk("pause_only_one", int'(evt_valid), 0);

        // timeout after a lone E0
        send(8'hE0);
        seen = 1'b0; waited = 0;
        for (int i = 1; i <= 3 * TCYC && !seen; i++) begin
            @(negedge clk);
            if (err_timeout) begin seen = 1'b1; waited = i; end
        end
        chk("timeout_seen", int'(seen), 1);
        chk("timeout_cycles", waited, TCYC);
        @(negedge clk);
        chk("timeout_one_cycle", int'(err_timeout), 0);
        send(8'h1C);
        idle(1);
        head("after_timeout", 'h1C, 0, 0);
        pop1();

        // overflow and simultaneous push/pop when full
        do_reset();
        chk("ovf_clear_start", int'(overflow), 0);
        for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
        idle(2);
        chk("ovf_set", int'(overflow), 1);
        head("full_head", 'h11, 0, 0);
        @(negedge clk); rx_done_tick = 1'b1; rx_data = 8'h16;
        @(negedge clk); rx_done_tick = 1'b0; rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        head("pp_a", 'h12, 0, 0); pop1();
        head("pp_b", 'h13, 0, 0); pop1();
        head("pp_c", 'h14, 0, 0); pop1();
        head("pp_d", 'h16, 0, 0); pop1();
        chk("pp_empty", int'(evt_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);
        do_reset();
        chk("ovf_cleared", int'(overflow), 0);

        // reset mid-sequence discards the E0 prefix
        send(8'hE0);
        do_reset();
        send(8'h1C);
        idle(1);
        head("mid_reset", 'h1C, 0, 0);
        pop1();

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
        $fatal(1);
    end

endmodule
